// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-fetch handshake between the sequencer and instruction memory
interface pc_sequencer_if;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic        IMEM_ACK;
  logic [31:0] IMEM_DATA;

  modport master (output IMEM_ADDR, output IMEM_REQ, input IMEM_ACK, input IMEM_DATA);
  modport slave  (input IMEM_ADDR, input IMEM_REQ, output IMEM_ACK, output IMEM_DATA);
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/exec/writeback sequencer owning the PC and retire count
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  pc_sequencer_if.master        imem,
  input  logic [31:0]           NEXT_PC,
  output logic [31:0]           INSTR,
  output logic [31:0]           PC,
  output logic                  EXEC_EN,
  input  logic                  MEM_BUSY,
  output logic                  WB_EN,
  input  logic                  HALT,
  output logic                  HALTED,
  output logic                  MISALIGN,
  output logic [31:0]           RETIRED
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [3:0]  EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEMWAIT,
    S_WB,
    S_HALTED,
    S_TRAP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        rst_q;
  logic [3:0]  exec_cnt;
  logic        req;
  logic        fetch_done;
  logic        misaligned;

  // rst_q keeps the request low for the cycle that still shows reset, so it
  // rises only in the first cycle after RST is released.
  assign fetch_done     = req && imem.IMEM_ACK;
  assign misaligned     = (NEXT_PC[1:0] != 2'b00);
  assign imem.IMEM_REQ  = req;
  assign imem.IMEM_ADDR = PC;

  always_ff @(posedge CLK) begin
    rst_q <= RST;
    if (RST) begin
      state    <= S_FETCH;
      PC       <= RESET_PC;
      INSTR    <= NOP_INSTR;
      RETIRED  <= 32'd0;
      MISALIGN <= 1'b0;
      exec_cnt <= 4'd0;
    end else begin
      state <= state_nx;
      if (fetch_done) begin
        INSTR    <= imem.IMEM_DATA;
        exec_cnt <= EXEC_LOAD;
      end else if (state == S_EXEC && exec_cnt != 4'd0) begin
        exec_cnt <= exec_cnt - 4'd1;
      end
      if (state == S_WB) begin
        if (misaligned) begin
          MISALIGN <= 1'b1;
        end else begin
          PC      <= NEXT_PC;
          RETIRED <= RETIRED + 32'd1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    EXEC_EN  = 1'b0;
    WB_EN    = 1'b0;
    HALTED   = 1'b0;
    case (state)
      S_FETCH: begin
        req = !rst_q;
        if (req && imem.IMEM_ACK) state_nx = S_EXEC;
      end
      S_EXEC: begin
        EXEC_EN = 1'b1;
        if (exec_cnt == 4'd0) state_nx = MEM_BUSY ? S_MEMWAIT : S_WB;
      end
      S_MEMWAIT: begin
        if (!MEM_BUSY) state_nx = S_WB;
      end
      S_WB: begin
        WB_EN = 1'b1;
        if (misaligned)  state_nx = S_TRAP;
        else if (HALT)   state_nx = S_HALTED;
        else             state_nx = S_FETCH;
      end
      S_HALTED: begin
        HALTED = 1'b1;
        if (!HALT) state_nx = S_FETCH;
      end
      S_TRAP: begin
        HALTED = 1'b1;
      end
      default: state_nx = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed per-cycle vector bench for pc_sequencer
module tb_pc_sequencer;
  logic clk;
  logic rst_a, rst_b;
  logic [31:0] npc_a, npc_b;
  logic busy_a, busy_b, halt_a, halt_b;
  logic [31:0] instr_a, pc_a, ret_a, instr_b, pc_b, ret_b;
  logic ex_a, wb_a, hl_a, mis_a, ex_b, wb_b, hl_b, mis_b;
  int checks = 0;
  int errors = 0;

  pc_sequencer_if ifa();
  pc_sequencer_if ifb();

  pc_sequencer #(.RESET_PC(32'h0000_0100), .EXEC_CYCLES(1)) dut_a (
    .CLK(clk), .RST(rst_a), .imem(ifa), .NEXT_PC(npc_a), .INSTR(instr_a), .PC(pc_a),
    .EXEC_EN(ex_a), .MEM_BUSY(busy_a), .WB_EN(wb_a), .HALT(halt_a), .HALTED(hl_a),
    .MISALIGN(mis_a), .RETIRED(ret_a));

  pc_sequencer #(.RESET_PC(32'h0000_0000), .EXEC_CYCLES(3)) dut_b (
    .CLK(clk), .RST(rst_b), .imem(ifb), .NEXT_PC(npc_b), .INSTR(instr_b), .PC(pc_b),
    .EXEC_EN(ex_b), .MEM_BUSY(busy_b), .WB_EN(wb_b), .HALT(halt_b), .HALTED(hl_b),
    .MISALIGN(mis_b), .RETIRED(ret_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ack;
    logic [31:0] data, npc;
    logic        busy, halt;
    logic        req, ex, wb, hl, mis;
    logic [31:0] pc, instr, ret;
  } vec_t;

  vec_t vq[$];

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  task automatic v(input logic rst, ack, input logic [31:0] data, npc, input logic busy, halt,
                   input logic req, ex, wb, hl, mis, input logic [31:0] pc, instr, ret);
    vec_t r;
    r.rst = rst; r.ack = ack; r.data = data; r.npc = npc; r.busy = busy; r.halt = halt;
    r.req = req; r.ex = ex; r.wb = wb; r.hl = hl; r.mis = mis; r.pc = pc; r.instr = instr; r.ret = ret;
    vq.push_back(r);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h want %h", name, row, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_a) begin
      checks++;
      if (ex_a && wb_a) begin
        errors++;
        $display("FAIL exec_wb_overlap got 1 want 0");
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    npc_a = '0; npc_b = '0; busy_a = 0; busy_b = 0; halt_a = 0; halt_b = 0;
    ifa.IMEM_ACK = 0; ifa.IMEM_DATA = '0; ifb.IMEM_ACK = 0; ifb.IMEM_DATA = '0;

    //  rst ack data           npc            busy halt | req ex wb hl mis pc             instr          ret
    v(1, 0, 32'h0,         32'h0,         0, 0,  0, 0, 0, 0, 0, 32'h100, NOP,           0);
    v(1, 0, 32'h0,         32'h0,         0, 0,  0, 0, 0, 0, 0, 32'h100, NOP,           0);
    v(0, 0, 32'h0,         32'h0,         0, 0,  0, 0, 0, 0, 0, 32'h100, NOP,           0);
    v(0, 1, 32'h1111_0001, 32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h100, NOP,           0);
    v(0, 0, 32'h0,         32'h0,         0, 0,  0, 1, 0, 0, 0, 32'h100, 32'h1111_0001, 0);
    v(0, 0, 32'h0,         32'h104,       0, 0,  0, 0, 1, 0, 0, 32'h100, 32'h1111_0001, 0);
    v(0, 1, 32'h1111_0002, 32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h104, 32'h1111_0001, 1);
    v(0, 0, 32'h0,         32'h0,         0, 0,  0, 1, 0, 0, 0, 32'h104, 32'h1111_0002, 1);
    v(0, 0, 32'h0,         32'h108,       0, 0,  0, 0, 1, 0, 0, 32'h104, 32'h1111_0002, 1);
    v(0, 1, 32'h1111_0003, 32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h108, 32'h1111_0002, 2);
    v(0, 0, 32'h0,         32'h0,         0, 0,  0, 1, 0, 0, 0, 32'h108, 32'h1111_0003, 2);
    v(0, 0, 32'h0,         32'h10C,       0, 0,  0, 0, 1, 0, 0, 32'h108, 32'h1111_0003, 2);
    v(0, 1, 32'h1111_0004, 32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h10C, 32'h1111_0003, 3);
    v(0, 0, 32'h0,         32'h0,         0, 0,  0, 1, 0, 0, 0, 32'h10C, 32'h1111_0004, 3);
    v(0, 0, 32'h0,         32'h110,       0, 0,  0, 0, 1, 0, 0, 32'h10C, 32'h1111_0004, 3);
    // fetch wait states: address held, data without ACK ignored
    v(0, 0, BAD,           32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h110, 32'h1111_0004, 4);
    v(0, 0, BAD,           32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h110, 32'h1111_0004, 4);
    v(0, 0, BAD,           32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h110, 32'h1111_0004, 4);
    v(0, 1, 32'h1111_0005, 32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h110, 32'h1111_0004, 4);
    v(0, 0, 32'h0,         32'h0,         0, 0,  0, 1, 0, 0, 0, 32'h110, 32'h1111_0005, 4);
    v(0, 0, 32'h0,         32'h200,       0, 0,  0, 0, 1, 0, 0, 32'h110, 32'h1111_0005, 4);
    v(0, 1, 32'h1111_0006, 32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h200, 32'h1111_0005, 5);
    // halt raised during exec: instruction completes first
    v(0, 0, 32'h0,         32'h0,         0, 1,  0, 1, 0, 0, 0, 32'h200, 32'h1111_0006, 5);
    v(0, 0, 32'h0,         32'h204,       0, 1,  0, 0, 1, 0, 0, 32'h200, 32'h1111_0006, 5);
    v(0, 0, 32'h0,         32'h0,         0, 1,  0, 0, 0, 1, 0, 32'h204, 32'h1111_0006, 6);
    v(0, 0, 32'h0,         32'h0,         0, 0,  0, 0, 0, 1, 0, 32'h204, 32'h1111_0006, 6);
    v(0, 1, 32'h1111_0007, 32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h204, 32'h1111_0006, 6);
    v(0, 0, 32'h0,         32'h0,         0, 0,  0, 1, 0, 0, 0, 32'h204, 32'h1111_0007, 6);
    // misaligned commit traps until reset
    v(0, 0, 32'h0,         32'h202,       0, 0,  0, 0, 1, 0, 0, 32'h204, 32'h1111_0007, 6);
    v(0, 0, 32'h0,         32'h0,         0, 0,  0, 0, 0, 1, 1, 32'h204, 32'h1111_0007, 6);
    v(0, 0, 32'h0,         32'h0,         0, 1,  0, 0, 0, 1, 1, 32'h204, 32'h1111_0007, 6);
    v(0, 1, BAD,           32'h0,         0, 0,  0, 0, 0, 1, 1, 32'h204, 32'h1111_0007, 6);
    v(1, 0, 32'h0,         32'h0,         0, 0,  0, 0, 0, 1, 1, 32'h204, 32'h1111_0007, 6);
    v(0, 0, 32'h0,         32'h0,         0, 0,  0, 0, 0, 0, 0, 32'h100, NOP,           0);
    v(0, 0, 32'h0,         32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h100, NOP,           0);
    // reset mid-fetch drops the request next cycle
    v(1, 0, 32'h0,         32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h100, NOP,           0);
    v(0, 0, 32'h0,         32'h0,         0, 0,  0, 0, 0, 0, 0, 32'h100, NOP,           0);
    v(0, 0, 32'h0,         32'h0,         0, 0,  1, 0, 0, 0, 0, 32'h100, NOP,           0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst_a = vq[i].rst; ifa.IMEM_ACK = vq[i].ack; ifa.IMEM_DATA = vq[i].data;
      npc_a = vq[i].npc; busy_a = vq[i].busy; halt_a = vq[i].halt;
      #1;
      chk("imem_req", i, {31'd0, ifa.IMEM_REQ}, {31'd0, vq[i].req});
      chk("imem_addr", i, ifa.IMEM_ADDR, vq[i].pc);
      chk("exec_en", i, {31'd0, ex_a}, {31'd0, vq[i].ex});
      chk("wb_en", i, {31'd0, wb_a}, {31'd0, vq[i].wb});
      chk("halted", i, {31'd0, hl_a}, {31'd0, vq[i].hl});
      chk("misalign", i, {31'd0, mis_a}, {31'd0, vq[i].mis});
      chk("pc", i, pc_a, vq[i].pc);
      chk("instr", i, instr_a, vq[i].instr);
      chk("retired", i, ret_a, vq[i].ret);
    end

    // three-cycle exec with a five-cycle memory stall, then PC wrap
    @(negedge clk); rst_b = 1'b0;
    @(negedge clk);
    chk("b_first_req", 100, {31'd0, ifb.IMEM_REQ}, 32'd1);
    ifb.IMEM_ACK = 1'b1; ifb.IMEM_DATA = 32'h00B0_0001;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ifb.IMEM_ACK = 1'b0; busy_b = (i < 5); npc_b = 32'hFFFF_FFFC;
      #1;
      chk("b_exec_en", 101 + i, {31'd0, ex_b}, {31'd0, (i < 3)});
      chk("b_wb_en", 101 + i, {31'd0, wb_b}, {31'd0, (i == 6)});
    end
    @(negedge clk); #1;
    chk("b_pc_hi", 108, pc_b, 32'hFFFF_FFFC);
    chk("b_retired", 108, ret_b, 32'd1);
    chk("b_req", 108, {31'd0, ifb.IMEM_REQ}, 32'd1);
    ifb.IMEM_ACK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ifb.IMEM_ACK = 1'b0; #1;
      chk("b_exec_en2", 109 + i, {31'd0, ex_b}, 32'd1);
    end
    @(negedge clk);
    npc_b = 32'h0000_0000; #1;
    chk("b_wb_en2", 112, {31'd0, wb_b}, 32'd1);
    @(negedge clk); #1;
    chk("b_pc_wrap", 113, pc_b, 32'h0000_0000);
    chk("b_retired2", 113, ret_b, 32'd2);
    chk("b_misalign", 113, {31'd0, mis_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
